// File: rtl/enter_byte_loader.sv
// rtl/enter_byte_loader.sv - push-button conditioning and two-operand byte loader
//
// Synchronizes the active-low nenter button and the switch byte, optionally
// debounces the button, detects presses (falling edge of the filtered level)
// and packs eight accepted bytes into two 32-bit operands.
//
// Optional feature macro: ENTER_DEBOUNCE_EN
//   defined     - debounce counter filters the synchronized button level
//   not defined - filtered level is the synchronized level; DEBOUNCE_CYCLES ignored
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  synchronous active-high reset
//   nenter       in   1  raw push-button, active-low, asynchronous
//   inputdata    in   8  slide-switch byte, asynchronous
//   dataA        out 32  first operand, first accepted byte in [7:0]
//   dataB        out 32  second operand, fifth accepted byte in [7:0]
//   data_ready   out  1  high while both operands are complete
//   byte_idx     out  3  bytes accepted in the current load
//   enter_pulse  out  1  one-cycle strobe per accepted press
module enter_byte_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nenter,
    input  logic [7:0]  inputdata,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic        data_ready,
    output logic [2:0]  byte_idx,
    output logic        enter_pulse
);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] READY  = 2'd2;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("enter_byte_loader: DEBOUNCE_CYCLES must be >= 2");
    end

    // ------------------------------------------------------------------
    // Input synchronizers. The button chain resets to 1 (released) so that
    // leaving reset never looks like a press.
    // ------------------------------------------------------------------
    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] data_s1_q;
    logic [7:0] data_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            sync1_q   <= nenter;
            sync2_q   <= sync1_q;
            data_s1_q <= inputdata;
            data_s2_q <= data_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Filtered button level
    // ------------------------------------------------------------------
    logic filtered;

`ifdef ENTER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filtered_q;
    logic             filtered_d;

    // The level only flips after DEBOUNCE_CYCLES consecutive differing
    // samples; any agreeing sample restarts the count.
    always_comb begin
        cnt_d      = '0;
        filtered_d = filtered_q;
        if (sync2_q != filtered_q) begin
            if (cnt_q == CNT_MAX) begin
                filtered_d = sync2_q;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            filtered_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            filtered_q <= filtered_d;
        end
    end

    assign filtered = filtered_q;
`else
    assign filtered = sync2_q;
`endif

    // ------------------------------------------------------------------
    // Press detect: 1 -> 0 transition of the filtered level only, so a held
    // button gives one press and the release is ignored.
    // ------------------------------------------------------------------
    logic filtered_prev_q;
    logic press;

    always_ff @(posedge clk) begin
        if (reset) begin
            filtered_prev_q <= 1'b1;
        end else begin
            filtered_prev_q <= filtered;
        end
    end

    assign press = filtered_prev_q & ~filtered;

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] data_a_q;
    logic [31:0] data_a_d;
    logic [31:0] data_b_q;
    logic [31:0] data_b_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic        ready_q;
    logic        ready_d;
    logic        pulse_q;
    logic        pulse_d;

    always_comb begin
        state_d  = state_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        idx_d    = idx_q;
        ready_d  = ready_q;
        pulse_d  = 1'b0;

        if (press) begin
            pulse_d = 1'b1;
            case (state_q)
                LOAD_A: begin
                    // idx_q is 0..3 here, so its low bits select the lane
                    data_a_d[{idx_q[1:0], 3'b000} +: 8] = data_s2_q;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd3) begin
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    // idx_q is 4..7 here; the low bits are idx_q - 4
                    data_b_d[{idx_q[1:0], 3'b000} +: 8] = data_s2_q;
                    if (idx_q == 3'd7) begin
                        state_d = READY;
                        idx_d   = 3'd0;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                READY: begin
                    state_d = LOAD_A;
                    idx_d   = 3'd0;
                    ready_d = 1'b0;
                end
                default: begin
                    state_d = LOAD_A;
                    idx_d   = 3'd0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD_A;
            data_a_q <= '0;
            data_b_q <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            pulse_q  <= pulse_d;
        end
    end

    assign dataA       = data_a_q;
    assign dataB       = data_b_q;
    assign data_ready  = ready_q;
    assign byte_idx    = idx_q;
    assign enter_pulse = pulse_q;

endmodule

// File: doc/enter_byte_loader.md
# enter_byte_loader

Front-end input stage of the Practica III board design: conditions the raw active-low `nenter` push-button and collects eight 8-bit switch values into two 32-bit operands. The stages are synchronizer, optional debounce, falling-edge detect, then a three-state load FSM. It sits directly upstream of the datapath unit and presents `dataA`, `dataB` and a `data_ready` level for the datapath to consume.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: number of consecutive differing synchronized samples needed before the filtered button level changes. Must be ≥2. Use ~500000 on the 50 MHz board.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `nenter`  in  1: raw push-button, active-low, asynchronous to `clk`.
- `inputdata`  in  8: slide-switch byte, asynchronous.
- `dataA`  out  32: first operand. First accepted byte goes to [7:0].
- `dataB`  out  32: second operand. Fifth accepted byte goes to [7:0].
- `data_ready`  out  1: level; high while both operands are complete.
- `byte_idx`  out  3: number of bytes accepted in the current load, 0..7.
- `enter_pulse`  out  1: one-cycle strobe per accepted press.

## Operation
- **Synchronizer:** 2-flop chain on `nenter`, giving `sync1` and `sync2`. A parallel 2-register pipeline on `inputdata` gives `data_s1` and `data_s2`.
- **Debounce** (see Configuration):
  - Counter `cnt` increments while `sync2 != filtered`.
  - When `sync2 == filtered`, `cnt` clears.
  - When `cnt == DEBOUNCE_CYCLES-1` and the values still differ: `filtered <= sync2` and `cnt <= 0`.
- **Press detect:** a press is accepted on the edge where the registered `filtered` goes from 1 to 0. The release edge (0 to 1) is ignored. A held button yields exactly one press.
- **FSM states:** LOAD_A, LOAD_B, READY.
  - LOAD_A: an accepted press writes `data_s2` into `dataA[8*byte_idx +: 8]` and increments `byte_idx`. At `byte_idx==3`, the state moves to LOAD_B.
  - LOAD_B: an accepted press writes `data_s2` into `dataB[8*(byte_idx-4) +: 8]` and increments `byte_idx`. At `byte_idx==7`, the state moves to READY, `byte_idx` returns to 0 and `data_ready` is set to 1.
  - READY: an accepted press writes no byte. It clears `data_ready`, sets `byte_idx` to 0 and moves to LOAD_A.
  - `dataA`/`dataB` keep their old contents until overwritten byte by byte.
- **Reset:**
  - State LOAD_A.
  - `dataA`, `dataB`, `byte_idx`, `data_ready`, `enter_pulse` and `cnt` are all 0.
  - `sync1`, `sync2` and `filtered` are 1 (released), so there is no spurious press on reset release.
  - `data_s1`/`data_s2` are 0.
- **Reset mid-load:** all partial bytes are discarded and the next press loads `dataA[7:0]`. Reset has priority over a press on the same edge.

## Timing
Let k be the first edge that samples `nenter` low.
- **Without debounce:**
  - The accept edge is k+2.
  - The byte written is `inputdata` as sampled at edge k.
  - `enter_pulse` is high from k+2 to k+3.
- **With debounce:**
  - The accept edge is k+2+`DEBOUNCE_CYCLES`, provided `nenter` stays low throughout.
  - The byte written is `inputdata` sampled two edges before the accept edge. Switches must be stable during the debounce window.
- **Register update:** `dataA`, `dataB`, `byte_idx`, `data_ready` and the state all update on the accept edge.
- **`data_ready`** rises on the 8th accept edge. It falls on the next accept edge.
- **Press spacing:** minimum press-to-press spacing is 2 cycles low + 1 cycle high without debounce. With debounce, each level must hold `DEBOUNCE_CYCLES` cycles.

## Configuration
- **`ENTER_DEBOUNCE_EN` defined:** the debounce counter is instantiated and `filtered` follows the rule above.
- **`ENTER_DEBOUNCE_EN` not defined:**
  - `filtered = sync2` and no counter is built.
  - `DEBOUNCE_CYCLES` is ignored.
  - Used for fast simulation with the 2-cycle press pattern.

## Test plan
- **Byte packing** (debounce off): presses with A8, 57, 15, 00 → `dataA=0x001557A8`, `data_ready=0`, `byte_idx=4`. Then presses with 4B, 51, B9, D1 → `dataB=0xD1B9514B`, `data_ready=1`, `byte_idx=0`.
- **Clear from READY:** one further press in READY → `data_ready=0`, `byte_idx=0`, `dataA`/`dataB` unchanged, one `enter_pulse`. The next press with 0xFF → `dataA=0x001557FF`.
- **Bounce rejection** (debounce on, `DEBOUNCE_CYCLES=16`): `nenter` low for 3 cycles, high 2, low 5, then high → no `enter_pulse`, `byte_idx` stays 0.
- **Held button:** `nenter` held low for 100 cycles → exactly one `enter_pulse`, at edge k+18. `byte_idx` 0→1, and nothing happens on release.
- **Reset mid-load:** reset asserted for 1 cycle after 5 bytes → all outputs 0. The next press with 0x3C → `dataA=0x0000003C`, `byte_idx=1`.
- **Reset release with button idle:** reset released while `nenter=1` → no `enter_pulse` for 50 cycles.
